// File: rtl/hazard_forward_unit_pkg.sv
// hazard_pkg: forwarding-select and hazard-FSM encodings plus the supported load-latency range.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10,
        FWD_LD  = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HZ_IDLE     = 2'd0,
        HZ_LU_STALL = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_t;

    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 3;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: pipeline <-> hazard unit bundle; perf counter outputs exist only with HAZARD_PERF_EN.
interface hazard_forward_unit_if #(
    parameter int REG_AW = 5,
    parameter int XLEN   = 32
);
    logic [REG_AW-1:0] i_id_rs1, i_id_rs2, i_ex_rd, i_mem_rd, i_wb_rd;
    logic              i_id_use_rs1, i_id_use_rs2;
    logic              i_ex_we, i_mem_we, i_wb_we;
    logic              i_ex_is_load, i_mem_is_load;
    logic              i_dmem_ready, i_br_taken;
    logic [1:0]        o_fwd_a_sel, o_fwd_b_sel, o_hz_state;
    logic              o_stall_if, o_stall_id, o_freeze, o_flush_id, o_flush_ex;
`ifdef HAZARD_PERF_EN
    logic [XLEN-1:0]   o_perf_stall_cnt, o_perf_flush_cnt;
`else
    localparam int unused_perf_w = XLEN;
`endif

    modport master (
        output i_id_rs1, i_id_rs2, i_ex_rd, i_mem_rd, i_wb_rd,
        output i_id_use_rs1, i_id_use_rs2, i_ex_we, i_mem_we, i_wb_we,
        output i_ex_is_load, i_mem_is_load, i_dmem_ready, i_br_taken,
        input  o_fwd_a_sel, o_fwd_b_sel, o_hz_state,
        input  o_stall_if, o_stall_id, o_freeze, o_flush_id, o_flush_ex
`ifdef HAZARD_PERF_EN
        , input o_perf_stall_cnt, o_perf_flush_cnt
`endif
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_ex_rd, i_mem_rd, i_wb_rd,
        input  i_id_use_rs1, i_id_use_rs2, i_ex_we, i_mem_we, i_wb_we,
        input  i_ex_is_load, i_mem_is_load, i_dmem_ready, i_br_taken,
        output o_fwd_a_sel, o_fwd_b_sel, o_hz_state,
        output o_stall_if, o_stall_id, o_freeze, o_flush_id, o_flush_ex
`ifdef HAZARD_PERF_EN
        , output o_perf_stall_cnt, o_perf_flush_cnt
`endif
    );

endinterface

// File: rtl/hazard_forward_unit_fwd_src_select.sv
// fwd_src_select: next EX forwarding source for one decode operand; EX beats MEM, x0 never matches.
module fwd_src_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_we,
    input  logic              i_ex_is_load,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_we,
    output fwd_sel_t          o_sel,
    output logic              o_ex_hit
);
    logic w_mem_hit;

    assign o_ex_hit  = i_ex_we && i_rs != '0 && i_rs == i_ex_rd;
    assign w_mem_hit = i_mem_we && i_rs != '0 && i_rs == i_mem_rd;
    assign o_sel     = o_ex_hit ? (i_ex_is_load ? FWD_LD : FWD_MEM) : (w_mem_hit ? FWD_WB : FWD_RF);

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: load-use stall / memory-wait freeze FSM with registered EX forwarding selects.
// Define HAZARD_PERF_EN to add saturating stall and branch-flush counters.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int XLEN     = 32
) (
    input logic                  clk,
    input logic                  rst,
    hazard_forward_unit_if.slave hz
);
    localparam int LAT = LOAD_LAT < LOAD_LAT_MIN ? LOAD_LAT_MIN :
                         (LOAD_LAT > LOAD_LAT_MAX ? LOAD_LAT_MAX : LOAD_LAT);
    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    hz_state_t  r_state, r_ret, w_next, w_ret_next, w_cur;
    logic [1:0] r_cnt, w_cnt_next;
    fwd_sel_t   r_fwd_a, r_fwd_b, w_sel_a, w_sel_b;
    logic       w_hit_a, w_hit_b, w_load_use, w_miss;
    logic       w_stall, w_freeze, w_flush_id, w_flush_ex, w_unused;

    fwd_src_select #(.REG_AW(REG_AW)) u_sel_a (
        .i_rs(hz.i_id_rs1), .i_ex_rd(hz.i_ex_rd), .i_ex_we(hz.i_ex_we), .i_ex_is_load(hz.i_ex_is_load),
        .i_mem_rd(hz.i_mem_rd), .i_mem_we(hz.i_mem_we), .o_sel(w_sel_a), .o_ex_hit(w_hit_a)
    );

    fwd_src_select #(.REG_AW(REG_AW)) u_sel_b (
        .i_rs(hz.i_id_rs2), .i_ex_rd(hz.i_ex_rd), .i_ex_we(hz.i_ex_we), .i_ex_is_load(hz.i_ex_is_load),
        .i_mem_rd(hz.i_mem_rd), .i_mem_we(hz.i_mem_we), .o_sel(w_sel_b), .o_ex_hit(w_hit_b)
    );

    assign w_load_use = hz.i_ex_is_load && ((w_hit_a && hz.i_id_use_rs1) || (w_hit_b && hz.i_id_use_rs2));
    // Once the response arrives, MEM_WAIT behaves for that cycle as the state it interrupted.
    assign w_cur  = (r_state == HZ_MEM_WAIT && hz.i_dmem_ready) ? r_ret : r_state;
    assign w_miss = !hz.i_dmem_ready && (r_state == HZ_MEM_WAIT || hz.i_mem_is_load);

    always_comb begin
        w_next     = HZ_IDLE;
        w_ret_next = r_ret;
        w_cnt_next = r_cnt;
        w_freeze   = 1'b0;
        w_stall    = 1'b0;
        w_flush_id = 1'b0;
        w_flush_ex = 1'b0;
        if (w_miss) begin
            w_next     = HZ_MEM_WAIT;
            w_ret_next = r_state == HZ_MEM_WAIT ? r_ret : r_state;
            w_freeze   = 1'b1;
            w_stall    = 1'b1;
        end else if (hz.i_br_taken) begin
            w_cnt_next = '0;
            w_flush_id = 1'b1;
            w_flush_ex = 1'b1;
        end else if (w_cur == HZ_LU_STALL) begin
            w_next     = r_cnt == '0 ? HZ_IDLE : HZ_LU_STALL;
            w_cnt_next = r_cnt == '0 ? '0 : r_cnt - 2'd1;
            w_stall    = 1'b1;
            w_flush_ex = 1'b1;
        end else if (w_load_use) begin
            w_next     = HZ_LU_STALL;
            w_cnt_next = CNT_INIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HZ_IDLE;
            r_ret   <= HZ_IDLE;
            r_cnt   <= '0;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_state <= w_next;
            r_ret   <= w_ret_next;
            r_cnt   <= w_cnt_next;
            // Any bubble entering EX carries no forwarding; a freeze keeps the EX operands in place.
            if (!w_freeze) begin
                r_fwd_a <= (w_stall || w_flush_ex) ? FWD_RF : w_sel_a;
                r_fwd_b <= (w_stall || w_flush_ex) ? FWD_RF : w_sel_b;
            end
        end
    end

    assign hz.o_fwd_a_sel = r_fwd_a;
    assign hz.o_fwd_b_sel = r_fwd_b;
    assign hz.o_hz_state  = r_state;
    assign hz.o_stall_if  = w_stall;
    assign hz.o_stall_id  = w_stall;
    assign hz.o_freeze    = w_freeze;
    assign hz.o_flush_id  = w_flush_id;
    assign hz.o_flush_ex  = w_flush_ex;
    assign w_unused       = ^{hz.i_wb_rd, hz.i_wb_we, 1'(XLEN)};

`ifdef HAZARD_PERF_EN
    logic [XLEN-1:0] r_perf_stall, r_perf_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + XLEN'(1);
            if (w_flush_id && r_perf_flush != '1)
                r_perf_flush <= r_perf_flush + XLEN'(1);
        end
    end

    assign hz.o_perf_stall_cnt = r_perf_stall;
    assign hz.o_perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: LOAD_LAT=1 and LOAD_LAT=3 units on shared stimulus, checked cycle by cycle
// against a bubble-count model through an expected-output queue.
module tb_hazard_forward_unit;

    typedef struct packed {
        logic [4:0] rs1, rs2, ex_rd, mem_rd, wb_rd;
        logic       use1, use2, ex_we, mem_we, wb_we, ex_ld, mem_ld, rdy, br;
    } stim_t;

    typedef struct {
        logic [10:0] e0, e1;
        int          cyc;
    } exp_t;

    localparam int LAT [2] = '{1, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    stim_t       cur = '0;
    logic [10:0] obs [2];
    exp_t        sb [$];
    int          n_cmp = 0, n_err = 0, cyc_n = 0;
    int          bub [2];
    bit          wt [2];
    logic [1:0]  ma [2], mb [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        hazard_forward_unit_if #(.REG_AW(5), .XLEN(32)) u_if ();
        assign u_if.i_id_rs1      = cur.rs1;
        assign u_if.i_id_rs2      = cur.rs2;
        assign u_if.i_ex_rd       = cur.ex_rd;
        assign u_if.i_mem_rd      = cur.mem_rd;
        assign u_if.i_wb_rd       = cur.wb_rd;
        assign u_if.i_id_use_rs1  = cur.use1;
        assign u_if.i_id_use_rs2  = cur.use2;
        assign u_if.i_ex_we       = cur.ex_we;
        assign u_if.i_mem_we      = cur.mem_we;
        assign u_if.i_wb_we       = cur.wb_we;
        assign u_if.i_ex_is_load  = cur.ex_ld;
        assign u_if.i_mem_is_load = cur.mem_ld;
        assign u_if.i_dmem_ready  = cur.rdy;
        assign u_if.i_br_taken    = cur.br;
        hazard_forward_unit #(.REG_AW(5), .LOAD_LAT(LAT[g]), .XLEN(32)) u_dut (
            .clk(clk),
            .rst(rst),
            .hz (u_if.slave)
        );
        assign obs[g] = {u_if.o_fwd_a_sel, u_if.o_fwd_b_sel, u_if.o_stall_if, u_if.o_stall_id,
                         u_if.o_freeze, u_if.o_flush_id, u_if.o_flush_ex, u_if.o_hz_state};
    end

    task automatic chk(string tag, logic [10:0] got, logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b expected=%b (fa fb sif sid frz fid fex st)", tag, got, exp);
        end
    endtask

    function automatic logic hit(logic [4:0] rs, logic [4:0] rd);
        return rs != 5'd0 && rs == rd;
    endfunction

    function automatic logic [1:0] nxt(logic [4:0] rs, stim_t s);
        if (s.ex_we && hit(rs, s.ex_rd)) return s.ex_ld ? 2'b11 : 2'b01;
        if (s.mem_we && hit(rs, s.mem_rd)) return 2'b10;
        return 2'b00;
    endfunction

    // Model: bub counts remaining load-use bubbles, wt marks an outstanding data-memory wait.
    task automatic model(int d, stim_t s, logic r, output logic [10:0] e);
        logic miss, fi, fx, st, lu;
        if (r) begin
            bub[d] = 0;
            wt[d]  = 0;
            ma[d]  = 2'b00;
            mb[d]  = 2'b00;
        end
        miss = !s.rdy && (wt[d] || s.mem_ld);
        fi   = !miss && s.br;
        fx   = fi || (!miss && bub[d] > 0);
        st   = miss || (!fi && bub[d] > 0);
        e    = {ma[d], mb[d], st, st, miss, fi, fx, wt[d] ? 2'd2 : (bub[d] > 0 ? 2'd1 : 2'd0)};
        if (r) return;
        lu = s.ex_ld && s.ex_we && ((hit(s.rs1, s.ex_rd) && s.use1) || (hit(s.rs2, s.ex_rd) && s.use2));
        if (!miss) begin
            ma[d] = (st || fx) ? 2'b00 : nxt(s.rs1, s);
            mb[d] = (st || fx) ? 2'b00 : nxt(s.rs2, s);
        end
        if (miss) wt[d] = 1;
        else begin
            wt[d] = 0;
            if (s.br) bub[d] = 0;
            else if (bub[d] > 0) bub[d]--;
            else if (lu) bub[d] = LAT[d];
        end
    endtask

    task automatic drive(stim_t s, logic r);
        exp_t x;
        @(posedge clk);
        #1;
        cur   = s;
        rst   = r;
        x.cyc = cyc_n++;
        model(0, s, r, x.e0);
        model(1, s, r, x.e1);
        sb.push_back(x);
    endtask

    function automatic stim_t mk(logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                 logic [4:0] exr, logic exw, logic exl,
                                 logic [4:0] memr, logic memw, logic meml, logic rdy, logic br);
        stim_t s;
        s        = '0;
        s.rs1    = rs1;
        s.use1   = u1;
        s.rs2    = rs2;
        s.use2   = u2;
        s.ex_rd  = exr;
        s.ex_we  = exw;
        s.ex_ld  = exl;
        s.mem_rd = memr;
        s.mem_we = memw;
        s.mem_ld = meml;
        s.rdy    = rdy;
        s.br     = br;
        s.wb_rd  = rs1;
        s.wb_we  = 1'b1;
        return s;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk($sformatf("lat1 c%0d", x.cyc), obs[0], x.e0);
            chk($sformatf("lat3 c%0d", x.cyc), obs[1], x.e1);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        stim_t idle, s;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(idle, 1);
        drive(idle, 1);
        // ALU result of x5 in EX forwarded to rs1
        drive(mk(5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0), 0);
        drive(idle, 0);
        // lw x7 in EX read by rs2: load-use bubbles
        drive(mk(0, 0, 7, 1, 7, 1, 1, 0, 0, 0, 1, 0), 0);
        repeat (3) drive(mk(0, 0, 7, 1, 0, 0, 0, 7, 1, 1, 1, 0), 0);
        repeat (2) drive(idle, 0);
        // nonzero selects, then a 4-cycle memory miss with a branch and new operands ignored
        drive(mk(5, 1, 6, 1, 5, 1, 0, 6, 1, 0, 1, 0), 0);
        drive(mk(9, 1, 3, 1, 3, 1, 0, 9, 1, 1, 0, 0), 0);
        drive(mk(9, 1, 3, 1, 3, 1, 0, 9, 1, 1, 0, 1), 0);
        repeat (2) drive(mk(9, 1, 3, 1, 3, 1, 0, 9, 1, 1, 0, 0), 0);
        drive(mk(9, 1, 3, 1, 3, 1, 0, 9, 1, 1, 1, 0), 0);
        drive(idle, 0);
        // branch and load-use together: flush wins
        drive(mk(0, 0, 7, 1, 7, 1, 1, 0, 0, 0, 1, 1), 0);
        drive(idle, 0);
        // x0 destination never stalls or forwards
        drive(mk(0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0), 0);
        drive(idle, 0);
        // reset in the middle of a load-use stall
        drive(mk(4, 1, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0), 0);
        drive(idle, 0);
        drive(idle, 1);
        drive(idle, 0);
        // memory miss arriving during a load-use stall
        drive(mk(4, 1, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0), 0);
        drive(idle, 0);
        repeat (2) drive(mk(0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0), 0);
        repeat (4) drive(idle, 0);
        for (int i = 0; i < 300; i++) begin
            s        = '0;
            s.rs1    = 5'($urandom_range(0, 3));
            s.rs2    = 5'($urandom_range(0, 3));
            s.ex_rd  = 5'($urandom_range(0, 3));
            s.mem_rd = 5'($urandom_range(0, 3));
            s.wb_rd  = 5'($urandom_range(0, 3));
            s.use1   = 1'($urandom_range(0, 1));
            s.use2   = 1'($urandom_range(0, 1));
            s.ex_we  = 1'($urandom_range(0, 1));
            s.mem_we = 1'($urandom_range(0, 1));
            s.wb_we  = 1'($urandom_range(0, 1));
            s.ex_ld  = 1'($urandom_range(0, 1));
            s.mem_ld = $urandom_range(0, 3) == 0;
            s.rdy    = $urandom_range(0, 3) != 0;
            s.br     = $urandom_range(0, 7) == 0;
            drive(s, $urandom_range(0, 99) == 0);
        end
        drive(idle, 0);
        @(negedge clk);
        #1;
        chk("drain", 11'(sb.size()), 11'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameters: REG_AW, default 5, register-index width; LOAD_LAT, default 1, range 1..3, load-use bubble cycles; XLEN, default 32, perf counter width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- id_rs1/id_rs2, in, REG_AW, decode source indices.
- id_use_rs1/id_use_rs2, in, 1, decode instruction reads the source.
- ex_rd/mem_rd/wb_rd, in, REG_AW, stage destinations.
- ex_we/mem_we/wb_we, in, 1, stage writes a register.
- ex_is_load/mem_is_load, in, 1, stage holds a load.
- dmem_ready, in, 1, data memory response valid.
- br_taken, in, 1, redirect resolved in EX.
- fwd_a_sel/fwd_b_sel, out, 2, registered EX operand source: 00 regfile, 01 MEM ALU result, 10 WB result, 11 WB load data.
- stall_if/stall_id, out, 1, hold PC and IF/ID register.
- freeze, out, 1, hold ID/EX, EX/MEM and MEM/WB registers.
- flush_id/flush_ex, out, 1, bubble IF/ID and ID/EX.
- hz_state, out, 2, FSM state for debug.

Function
REQ-003 Register index 0 never matches any hazard or forward comparison.
REQ-004 load_use = ex_is_load & ex_we & (id_rs1 matches ex_rd & id_use_rs1, or id_rs2 matches ex_rd & id_use_rs2).
REQ-005 Next select per operand: match with ex_rd & ex_we -> 01, or 11 if ex_is_load; otherwise match with mem_rd & mem_we -> 10; otherwise 00. EX has priority over MEM.
REQ-006 fwd_*_sel registers the next select on each clk edge where freeze=0 and stall_id=0. On flush_ex or a stall bubble the registers load 00. They hold while freeze=1.
REQ-007 Operands that match only wb_rd select 00; the regfile is write-before-read.
REQ-008 FSM states: IDLE=0, LU_STALL=1, MEM_WAIT=2.
REQ-009 IDLE -> MEM_WAIT when mem_is_load & ~dmem_ready. Otherwise IDLE -> LU_STALL when load_use & ~br_taken, loading the counter with LOAD_LAT-1.
REQ-010 LU_STALL: stall_if=stall_id=flush_ex=1. Decrement the counter each cycle and return to IDLE when it is 0. Total bubbles equal LOAD_LAT exactly.
REQ-011 MEM_WAIT: freeze=stall_if=stall_id=1 and flushes are 0. Return to the state entered from on the first cycle dmem_ready=1; the LU counter does not decrement while waiting.
REQ-012 br_taken while not frozen: flush_id=flush_ex=1 for that cycle, abort LU_STALL to IDLE, and zero both select registers.
REQ-013 br_taken while freeze=1 is ignored; the pipeline holds it until release.
REQ-014 br_taken and load_use in the same cycle: the flush wins and no stall is entered.
REQ-015 All outputs other than fwd_*_sel and hz_state are combinational from state and inputs, with zero-cycle latency.

Reset
REQ-016 rst asserted: state=IDLE, counter=0, fwd_a_sel=fwd_b_sel=00, stall/freeze/flush=0, perf counters=0.
REQ-017 rst mid-stall or mid-wait discards the pending operation immediately.

Configuration
REQ-018 With HAZARD_PERF_EN defined, add outputs perf_stall_cnt (XLEN) and perf_flush_cnt (XLEN):
- perf_stall_cnt increments on each cycle with stall_id=1.
- perf_flush_cnt increments on each br_taken flush.
- Both saturate at all-ones.
REQ-019 Without HAZARD_PERF_EN these ports and their logic do not exist.

Structure
REQ-020 Package hazard_pkg holds the fwd_sel_t enum (00/01/10/11), the hz_state_t enum and the LOAD_LAT bounds.
REQ-021 Sub-module fwd_src_select computes the REQ-005 next select for one operand and is instantiated twice.

Verification
REQ-022 The bench covers these directed scenarios:
- add x5 in EX, decode reads rs1=x5 -> next cycle fwd_a_sel=01, no stall.
- lw x7 in EX, decode reads rs2=x7, LOAD_LAT=1 -> exactly one cycle stall_id=flush_ex=1, then fwd_b_sel=11.
- Same as above with LOAD_LAT=3 -> three bubbles, state 1,1,1,0.
- lw in MEM with dmem_ready low for 4 cycles -> freeze=1 for 4 cycles, selects held, resume on the ready cycle.
- br_taken with load_use in the same cycle -> flush_id=flush_ex=1, state stays 0, selects 00.
- rd=x0 load in EX with decode reading x0 -> no stall, sel 00; rst pulsed mid-LU_STALL -> all outputs zero.
